// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: op codes, FSM states and
// the shortest-path distance helper used by SEEK.
`default_nettype none

package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic        up;
    logic [31:0] steps;
  } seek_t;

  // Shortest wrap-around path from count to target; a half-circle tie goes up.
  function automatic seek_t seek_distance(input logic [31:0] count,
                                          input logic [31:0] target,
                                          input int unsigned width);
    logic [31:0] mask;
    logic [31:0] d;
    logic [31:0] half;
    seek_t       res;
    mask = (32'd1 << width) - 32'd1;
    d    = (target - count) & mask;
    half = 32'd1 << (width - 1);
    res.up    = (d <= half);
    res.steps = (d <= half) ? d : ((~d + 32'd1) & mask);
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/up_down_counter.sv
// Loadable wrap-around up/down counter; set has priority over enable.
`default_nettype none

module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (set) begin
      count <= set_value;
    end else if (enable) begin
      count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for one up_down_counter: LOAD, UP/DOWN by N and
// SEEK-to-value, with a one-cycle done pulse carrying the resulting count.
`default_nettype none

module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_value,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              cnt_enable,
  output logic              cnt_set,
  output logic [WIDTH-1:0]  cnt_set_value,
  output logic              cnt_up_down,
  input  logic [WIDTH-1:0]  cnt_count,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  done_count
);

  state_t              r_state;
  logic [STEP_W-1:0]   r_rem;
  logic                r_cnt_set;
  logic [WIDTH-1:0]    r_cnt_set_value;
  logic                r_cnt_up_down;
  logic                r_done;

  seek_t               w_seek;
  logic [STEP_W-1:0]   w_seek_steps;
  logic                w_unused_seek;

  // STEP_W must be at least WIDTH so a half-circle SEEK distance fits.
  assign w_seek        = seek_distance(32'(cnt_count), 32'(cmd_value), WIDTH);
  assign w_seek_steps  = STEP_W'(w_seek.steps);
  assign w_unused_seek = ^w_seek.steps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_rem           <= '0;
      r_cnt_set       <= 1'b0;
      r_cnt_set_value <= '0;
      r_cnt_up_down   <= 1'b1;
      r_done          <= 1'b0;
    end else begin
      r_cnt_set       <= 1'b0;
      r_cnt_set_value <= '0;
      r_done          <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                r_state         <= ST_LOAD;
                r_cnt_set       <= 1'b1;
                r_cnt_set_value <= cmd_value;
              end
              OP_UP, OP_DOWN: begin
                r_rem         <= cmd_steps;
                r_cnt_up_down <= (cmd_op == OP_UP);
                if (cmd_steps == '0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_RUN;
                end
              end
              default: begin
                r_rem         <= w_seek_steps;
                r_cnt_up_down <= w_seek.up;
                if (w_seek_steps == '0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_RUN;
                end
              end
            endcase
          end
        end
        ST_LOAD: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_rem <= r_rem - STEP_W'(1);
            if (r_rem == STEP_W'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Enable is gated combinationally so an abort suppresses the step in the same cycle.
  assign cnt_enable    = (r_state == ST_RUN) && !abort;
  assign cnt_set       = r_cnt_set;
  assign cnt_set_value = r_cnt_set_value;
  assign cnt_up_down   = r_cnt_up_down;
  assign busy          = (r_state != ST_IDLE);
  assign cmd_ready     = (r_state == ST_IDLE);
  assign done          = r_done;
  assign done_count    = r_done ? cnt_count : '0;

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer driving a real up_down_counter.
`default_nettype none

module tb_counter_sequencer;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_value = 4'd0;
  logic [7:0] cmd_steps = 8'd0;
  logic       abort = 1'b0;
  logic       cnt_enable, cnt_set, cnt_up_down, busy, done;
  logic [3:0] cnt_set_value, cnt_count, done_count;
  logic       cnt_rst;

  assign cnt_rst = ~reset;

  counter_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_value(cmd_value), .cmd_steps(cmd_steps), .abort(abort),
    .cnt_enable(cnt_enable), .cnt_set(cnt_set), .cnt_set_value(cnt_set_value),
    .cnt_up_down(cnt_up_down), .cnt_count(cnt_count), .busy(busy), .done(done),
    .done_count(done_count)
  );

  up_down_counter #(.WIDTH(4)) u_cnt (
    .clk(clk), .rst(cnt_rst), .enable(cnt_enable), .set(cnt_set),
    .set_value(cnt_set_value), .up_down(cnt_up_down), .count(cnt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] value;
    logic [7:0] steps;
    logic [3:0] exp_count;
    int         exp_en;
    logic       exp_up;
    int         exp_set;
    int         exp_lat;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   en_n = 0, dir_up_n = 0, dir_dn_n = 0, set_n = 0, acc_cyc = 0;
  logic [3:0] last_set_val = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] value,
                              input logic [7:0] steps, input logic [3:0] cnt,
                              input int en, input logic up);
    vec_t v;
    v.op = op; v.value = value; v.steps = steps; v.exp_count = cnt;
    v.exp_en = en; v.exp_up = up;
    v.exp_set = (op == OP_LOAD) ? 1 : 0;
    v.exp_lat = (op == OP_LOAD) ? 2 : en + 1;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: tallies counter activity per command and scores each done pulse.
  always @(negedge clk) begin
    if (reset && cmd_valid && cmd_ready) begin
      en_n = 0; dir_up_n = 0; dir_dn_n = 0; set_n = 0; acc_cyc = cyc;
    end
    if (cnt_enable) begin
      en_n++;
      if (cnt_up_down) dir_up_n++; else dir_dn_n++;
    end
    if (cnt_set) begin
      set_n++;
      last_set_val = cnt_set_value;
    end
    if (cnt_set && cnt_enable) check("set_and_enable", 1, 0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check("done_count", done_count, e.exp_count);
        check("enable_cycles", en_n, e.exp_en);
        check("direction_cycles", e.exp_up ? dir_up_n : dir_dn_n, e.exp_en);
        check("set_cycles", set_n, e.exp_set);
        check("latency", cyc - acc_cyc, e.exp_lat);
        if (e.exp_set != 0) check("set_value", last_set_val, e.exp_count);
      end
    end else if (done_count != 4'd0) begin
      check("done_count_idle", done_count, 0);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] value, input logic [7:0] steps);
    bit acc = 0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_value = value; cmd_steps = steps;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1; break; end
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(OP_LOAD, 4'b1010, 8'd0,  4'b1010, 0,  1'b1);
    tbl[1]  = mk(OP_UP,   4'b0000, 8'd3,  4'b1101, 3,  1'b1);
    tbl[2]  = mk(OP_LOAD, 4'b0010, 8'd0,  4'b0010, 0,  1'b1);
    tbl[3]  = mk(OP_DOWN, 4'b0000, 8'd5,  4'b1101, 5,  1'b0);
    tbl[4]  = mk(OP_UP,   4'b0000, 8'd0,  4'b1101, 0,  1'b1);
    tbl[5]  = mk(OP_SEEK, 4'b0001, 8'd0,  4'b0001, 4,  1'b1);
    tbl[6]  = mk(OP_LOAD, 4'b0000, 8'd0,  4'b0000, 0,  1'b1);
    tbl[7]  = mk(OP_SEEK, 4'b1000, 8'd0,  4'b1000, 8,  1'b1);
    tbl[8]  = mk(OP_SEEK, 4'b1000, 8'd0,  4'b1000, 0,  1'b1);
    tbl[9]  = mk(OP_SEEK, 4'b0011, 8'd0,  4'b0011, 5,  1'b0);
    tbl[10] = mk(OP_DOWN, 4'b0000, 8'd20, 4'b1111, 20, 1'b0);
    tbl[11] = mk(OP_DOWN, 4'b0101, 8'd0,  4'b1111, 0,  1'b0);
    tbl[12] = mk(OP_SEEK, 4'b0111, 8'd0,  4'b0111, 8,  1'b1);

    repeat (3) @(posedge clk);
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_enable", cnt_enable, 0);
    check("rst_set", cnt_set, 0);
    check("rst_set_value", cnt_set_value, 0);
    check("rst_up_down", cnt_up_down, 1);
    check("rst_done", done, 0);
    check("rst_done_count", done_count, 0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sb.push_back(tbl[i]);
      issue(tbl[i].op, tbl[i].value, tbl[i].steps);
      wait_done();
    end

    // Abort after two enable cycles of UP 6 from zero.
    begin
      vec_t e;
      int n = 0;
      sb.push_back(mk(OP_LOAD, 4'b0000, 8'd0, 4'b0000, 0, 1'b1));
      issue(OP_LOAD, 4'b0000, 8'd0);
      wait_done();
      e = mk(OP_UP, 4'b0000, 8'd6, 4'b0010, 2, 1'b1);
      e.exp_lat = 4;
      sb.push_back(e);
      issue(OP_UP, 4'b0000, 8'd6);
      for (int i = 0; i < 50 && n < 2; i++) begin
        @(negedge clk);
        if (cnt_enable) n++;
      end
      @(posedge clk); #2;
      abort = 1'b1;
      @(negedge clk);
      check("abort_enable_low", cnt_enable, 0);
      @(posedge clk); #2;
      abort = 1'b0;
      wait_done();
      sb.push_back(mk(OP_UP, 4'b0000, 8'd1, 4'b0011, 1, 1'b1));
      issue(OP_UP, 4'b0000, 8'd1);
      wait_done();
    end

    // Reset mid-RUN: outputs drop asynchronously and no done pulse follows.
    begin
      int n = 0;
      issue(OP_UP, 4'b0000, 8'd10);
      for (int i = 0; i < 50 && n < 3; i++) begin
        @(negedge clk);
        if (cnt_enable) n++;
      end
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("mid_rst_enable", cnt_enable, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_up_down", cnt_up_down, 1);
      check("mid_rst_done", done, 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_count", cnt_count, 0);
      repeat (3) @(negedge clk);
      check("post_rst_no_done", sb.size(), 0);
    end

    // cmd_valid held while busy is taken only the cycle after done.
    begin
      bit seen = 0;
      sb.push_back(mk(OP_LOAD, 4'b0101, 8'd0, 4'b0101, 0, 1'b1));
      sb.push_back(mk(OP_UP,   4'b0000, 8'd2, 4'b0111, 2, 1'b1));
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_value = 4'b0101; cmd_steps = 8'd0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cmd_ready) break;
      end
      @(posedge clk); #2;
      cmd_op = OP_UP; cmd_value = 4'b0000; cmd_steps = 8'd2;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin seen = 1; break; end
        check("held_not_ready", cmd_ready, 0);
      end
      check("held_done_seen", seen, 1);
      check("held_ready_at_done", cmd_ready, 0);
      @(negedge clk);
      check("held_ready_after_done", cmd_ready, 1);
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
